// File: rtl/tdm_demux_if.sv
// Link-side and channel-side bus of the TDM 1-to-4 demultiplexer.
// master drives the serial beats and consumes the channel registers; slave is the demux.
interface tdm_demux_if #(
  parameter int DATA_W = 8
);
  logic              din_valid;
  logic              din_sync;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout_a;
  logic [DATA_W-1:0] dout_b;
  logic [DATA_W-1:0] dout_c;
  logic [DATA_W-1:0] dout_d;
  logic [3:0]        dout_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;
  logic [1:0]        slot;

  modport master (
    output din_valid, din_sync, din,
    input  dout_a, dout_b, dout_c, dout_d, dout_valid, frame_done, sync_err, locked, slot
  );

  modport slave (
    input  din_valid, din_sync, din,
    output dout_a, dout_b, dout_c, dout_d, dout_valid, frame_done, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux.sv
// Receive end of the 4x1 TDM channel: routes slot 0..3 of each frame to channel
// registers a..d and tracks frame alignment with a HUNT/LOCK state machine.
module tdm_demux #(
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_r;
  logic [1:0]        cnt_r;
  logic [DATA_W-1:0] dout_a_r;
  logic [DATA_W-1:0] dout_b_r;
  logic [DATA_W-1:0] dout_c_r;
  logic [DATA_W-1:0] dout_d_r;
  logic [3:0]        dout_valid_r;
  logic              frame_done_r;
  logic              sync_err_r;
  logic              locked_r;

  // Alignment FSM, slot counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_HUNT;
      cnt_r        <= 2'd0;
      dout_a_r     <= {DATA_W{1'b0}};
      dout_b_r     <= {DATA_W{1'b0}};
      dout_c_r     <= {DATA_W{1'b0}};
      dout_d_r     <= {DATA_W{1'b0}};
      dout_valid_r <= 4'b0000;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      dout_valid_r <= 4'b0000;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      if (bus.din_valid) begin
        case (state_r)
          ST_HUNT: begin
            if (bus.din_sync) begin
              dout_a_r     <= bus.din;
              dout_valid_r <= 4'b0001;
              cnt_r        <= 2'd1;
              state_r      <= ST_LOCK;
              locked_r     <= 1'b1;
            end else begin
              cnt_r <= 2'd0;
            end
          end
          ST_LOCK: begin
            if (bus.din_sync) begin
              // A sync anywhere but slot 0 abandons the partial frame and realigns.
              dout_a_r     <= bus.din;
              dout_valid_r <= 4'b0001;
              cnt_r        <= 2'd1;
              sync_err_r   <= (cnt_r != 2'd0);
            end else if (cnt_r == 2'd0) begin
              sync_err_r <= 1'b1;
              cnt_r      <= 2'd0;
              state_r    <= ST_HUNT;
              locked_r   <= 1'b0;
            end else begin
              case (cnt_r)
                2'd1:    dout_b_r <= bus.din;
                2'd2:    dout_c_r <= bus.din;
                2'd3:    dout_d_r <= bus.din;
                default: dout_a_r <= dout_a_r;
              endcase
              dout_valid_r <= 4'b0001 << cnt_r;
              frame_done_r <= (cnt_r == 2'd3);
              cnt_r        <= cnt_r + 2'd1;
            end
          end
          default: begin
            state_r  <= ST_HUNT;
            cnt_r    <= 2'd0;
            locked_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.dout_a     = dout_a_r;
  assign bus.dout_b     = dout_b_r;
  assign bus.dout_c     = dout_c_r;
  assign bus.dout_d     = dout_d_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.sync_err   = sync_err_r;
  assign bus.locked     = locked_r;
  assign bus.slot       = cnt_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: hand-computed frames, alignment errors, gaps and async reset.
module tb_tdm_demux;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  tdm_demux_if #(.DATA_W(8)) bus ();

  tdm_demux #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic [3:0] dv, input logic fd, input logic se,
                         input logic lk, input logic [1:0] sl);
    check({tag, ".a"},  {24'd0, bus.dout_a}, {24'd0, a});
    check({tag, ".b"},  {24'd0, bus.dout_b}, {24'd0, b});
    check({tag, ".c"},  {24'd0, bus.dout_c}, {24'd0, c});
    check({tag, ".d"},  {24'd0, bus.dout_d}, {24'd0, d});
    check({tag, ".dv"}, {28'd0, bus.dout_valid}, {28'd0, dv});
    check({tag, ".fd"}, {31'd0, bus.frame_done}, {31'd0, fd});
    check({tag, ".se"}, {31'd0, bus.sync_err}, {31'd0, se});
    check({tag, ".lk"}, {31'd0, bus.locked}, {31'd0, lk});
    check({tag, ".sl"}, {30'd0, bus.slot}, {30'd0, sl});
  endtask

  // Drive one cycle of input, then sample just after the rising edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus.din_valid = v;
    bus.din_sync  = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
    bus.din       = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    tests = 0;
    fails = 0;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
    bus.din       = 8'h00;
    do_reset();
    chk_all("rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);

    // Basic frame
    step(1'b1, 1'b1, 8'h11); chk_all("s1b0", 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 8'h22); chk_all("s1b1", 8'h11, 8'h22, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b0, 8'h33); chk_all("s1b2", 8'h11, 8'h22, 8'h33, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 8'h44); chk_all("s1b3", 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 8'h00); chk_all("s1idle", 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0);

    // Beats before the first sync are dropped silently
    do_reset();
    step(1'b1, 1'b0, 8'hAA); chk_all("s2aa", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'hBB); chk_all("s2bb", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 8'h10); chk_all("s2b0", 8'h10, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 8'h20); chk_all("s2b1", 8'h10, 8'h20, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b0, 8'h30); chk_all("s2b2", 8'h10, 8'h20, 8'h30, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 8'h40); chk_all("s2b3", 8'h10, 8'h20, 8'h30, 8'h40, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);

    // Early sync at slot 2
    step(1'b1, 1'b1, 8'h61); chk_all("s3b0", 8'h61, 8'h20, 8'h30, 8'h40, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 8'h62); chk_all("s3b1", 8'h61, 8'h62, 8'h30, 8'h40, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b1, 8'h5A); chk_all("s3early", 8'h5A, 8'h62, 8'h30, 8'h40, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd1);

    // Missing sync at slot 0 drops to HUNT, then relock
    step(1'b1, 1'b0, 8'h63); chk_all("s4b2", 8'h5A, 8'h63, 8'h30, 8'h40, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b0, 8'h64); chk_all("s4b3", 8'h5A, 8'h63, 8'h64, 8'h40, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
    step(1'b1, 1'b0, 8'h65); chk_all("s4b4", 8'h5A, 8'h63, 8'h64, 8'h65, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 8'h77); chk_all("s4miss", 8'h5A, 8'h63, 8'h64, 8'h65, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 8'h78); chk_all("s4hunt", 8'h5A, 8'h63, 8'h64, 8'h65, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 8'h88); chk_all("s4relock", 8'h88, 8'h63, 8'h64, 8'h65, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 8'h89); step(1'b1, 1'b0, 8'h8A); step(1'b1, 1'b0, 8'h8B);
    chk_all("s4end", 8'h88, 8'h89, 8'h8A, 8'h8B, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);

    // Gapped frame; sync toggling without valid must be ignored
    step(1'b1, 1'b1, 8'h01); chk_all("s5b0", 8'h01, 8'h89, 8'h8A, 8'h8B, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hEE); chk_all("s5g0", 8'h01, 8'h89, 8'h8A, 8'h8B, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
    end
    step(1'b1, 1'b0, 8'h02); chk_all("s5b1", 8'h01, 8'h02, 8'h8A, 8'h8B, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hEE); chk_all("s5g1", 8'h01, 8'h02, 8'h8A, 8'h8B, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
    end
    step(1'b1, 1'b0, 8'h03); chk_all("s5b2", 8'h01, 8'h02, 8'h03, 8'h8B, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hEE); chk_all("s5g2", 8'h01, 8'h02, 8'h03, 8'h8B, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3);
    end
    step(1'b1, 1'b0, 8'h04); chk_all("s5b3", 8'h01, 8'h02, 8'h03, 8'h04, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd0);

    // Async reset mid-frame, between clock edges
    step(1'b1, 1'b1, 8'h21);
    step(1'b1, 1'b0, 8'h22); chk_all("s6pre", 8'h21, 8'h22, 8'h03, 8'h04, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("s6rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h33); chk_all("s6drop", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
